// File: rtl/nfu3_pkg.sv
// Shared types and constants for the NFU-3 sequencer: FSM states, sigmoid
// pipeline latency and the admit-register helpers.
package nfu3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int NFU3_LAT = 2;
  localparam int SEG_W    = 4;
  localparam int ADMIT_W  = NFU3_LAT + 1;
  localparam int INFL_W   = $clog2(ADMIT_W + 1);

  // Number of vectors currently travelling through the sigmoid pipeline.
  function automatic logic [INFL_W-1:0] admit_popcount(input logic [ADMIT_W-1:0] v);
    logic [INFL_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < ADMIT_W; i++) begin
      cnt = cnt + INFL_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/nfu3_out_fifo.sv
// Result buffer between the NFU-3 pipeline and the downstream consumer:
// DEPTH x W synchronous FIFO exposing its occupancy for credit accounting.
module nfu3_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  assign o_empty = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!full || do_pop);
  assign o_count = cnt_q;
  assign o_data  = o_empty ? '0 : mem_q[rd_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    if (do_pop)  rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= i_data;
  end

  // Credit admission upstream must make a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && full));

endmodule

// File: rtl/nfu3_ctrl.sv
// NFU-3 sequencer: coefficient reload, rounder control hold and credit-based
// metering of NFU-2 vectors. Define NFU3_CTRL_PERF_EN to build the perf counters.
module nfu3_ctrl
  import nfu3_pkg::*;
#(
  parameter int N       = 16,
  parameter int Tn      = 16,
  parameter int BIT_IDX = 4,
  parameter int NUM_SEG = 16,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cfg_start,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [2*N-1:0]      i_cfg_coef,
  input  logic [N-1:0]        i_max,
  input  logic [N-1:0]        i_min,
  input  logic [BIT_IDX-1:0]  i_offset,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [Tn*N-1:0]     i_in_data,
  output logic [Tn*N-1:0]     o_x,
  output logic [2*N-1:0]      o_coef,
  output logic                o_load_coef,
  output logic [N-1:0]        o_max,
  output logic [N-1:0]        o_min,
  output logic [BIT_IDX-1:0]  o_offset,
  input  logic [Tn*N-1:0]     i_nfu3_out,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [Tn*N-1:0]     o_out_data,
  output logic                o_coef_loaded,
  output logic [31:0]         o_perf_vec_cnt,
  output logic [31:0]         o_perf_stall_cnt
);

  localparam int SEG_CW = $clog2(NUM_SEG + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int CRD_W  = CNT_W + 1;

  state_e             state_q, state_d;
  logic [SEG_CW-1:0]  seg_q, seg_d;
  logic [ADMIT_W-1:0] admit_q, admit_d;
  logic [Tn*N-1:0]    x_q, x_d;
  logic [2*N-1:0]     coef_q, coef_d;
  logic               load_coef_q, load_coef_d;
  logic [N-1:0]       max_q, max_d, min_q, min_d;
  logic [BIT_IDX-1:0] offset_q, offset_d;
  logic               loaded_q, loaded_d;

  logic [INFL_W-1:0]  inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, pop;
  logic [CRD_W-1:0]   committed, limit;
  logic               in_ready, in_acc, cfg_ready, cfg_acc;

  assign inflight  = admit_popcount(admit_q);
  assign pop       = !fifo_empty && i_out_ready;

  // A slot freed by this cycle's pop is reusable: the new vector lands NFU3_LAT+1 cycles later.
  assign committed = CRD_W'(inflight) + CRD_W'(fifo_count);
  assign limit     = CRD_W'(DEPTH) + CRD_W'(pop);
  assign in_ready  = (state_q == ST_RUN) && (committed < limit);
  assign in_acc    = in_ready && i_in_valid;
  assign cfg_ready = (state_q == ST_LOAD) && (seg_q < SEG_CW'(NUM_SEG));
  assign cfg_acc   = cfg_ready && i_cfg_valid;

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    admit_d     = {admit_q[ADMIT_W-2:0], in_acc};
    x_d         = x_q;
    coef_d      = coef_q;
    load_coef_d = cfg_acc;
    max_d       = max_q;
    min_d       = min_q;
    offset_d    = offset_q;
    loaded_d    = loaded_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_cfg_start) begin
          state_d  = ST_LOAD;
          seg_d    = '0;
          max_d    = i_max;
          min_d    = i_min;
          offset_d = i_offset;
        end
      end
      ST_LOAD: begin
        if (cfg_acc) begin
          coef_d = i_cfg_coef;
          x_d    = {Tn{seg_q[SEG_W-1:0], {(N-SEG_W){1'b0}}}};
          seg_d  = seg_q + SEG_CW'(1);
        end else if (seg_q == SEG_CW'(NUM_SEG)) begin
          state_d  = ST_RUN;
          loaded_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (in_acc) x_d = i_in_data;
        if (i_cfg_start) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Controls change only once the pipeline no longer holds vectors that used them.
        if (inflight == '0) begin
          state_d  = ST_LOAD;
          seg_d    = '0;
          max_d    = i_max;
          min_d    = i_min;
          offset_d = i_offset;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seg_q       <= '0;
      admit_q     <= '0;
      x_q         <= '0;
      coef_q      <= '0;
      load_coef_q <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
      offset_q    <= '0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      admit_q     <= admit_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
      load_coef_q <= load_coef_d;
      max_q       <= max_d;
      min_q       <= min_d;
      offset_q    <= offset_d;
      loaded_q    <= loaded_d;
    end
  end

  nfu3_out_fifo #(
    .DEPTH (DEPTH),
    .W     (Tn * N)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (admit_q[ADMIT_W-1]),
    .i_data  (i_nfu3_out),
    .i_pop   (pop),
    .o_data  (o_out_data),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_cfg_ready   = cfg_ready;
  assign o_in_ready    = in_ready;
  assign o_x           = x_q;
  assign o_coef        = coef_q;
  assign o_load_coef   = load_coef_q;
  assign o_max         = max_q;
  assign o_min         = min_q;
  assign o_offset      = offset_q;
  assign o_out_valid   = !fifo_empty;
  assign o_coef_loaded = loaded_q;

`ifdef NFU3_CTRL_PERF_EN
  logic [31:0] vec_cnt_q, vec_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    vec_cnt_d   = vec_cnt_q + {31'b0, in_acc};
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN || state_q == ST_DRAIN) && i_in_valid && !in_ready)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      vec_cnt_q   <= vec_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_perf_vec_cnt   = vec_cnt_q;
  assign o_perf_stall_cnt = stall_cnt_q;
`else
  assign o_perf_vec_cnt   = '0;
  assign o_perf_stall_cnt = '0;
`endif

endmodule
